// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master arbiter (priority, lock, round-robin) with RAM/IO decode
// and a one-cycle registered read-return path back to the issuing master.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 8,
    parameter bit PRIO_EN        = 1'b1,
    parameter int PRIO_IDX       = 0
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]             m_din,
    output logic                              ram_en,
    output logic                              ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
    output logic [DATA_WIDTH-1:0]             ram_dout,
    input  logic [DATA_WIDTH-1:0]             ram_din,
    output logic                              io_en,
    output logic                              io_wr,
    output logic [2:0]                        io_sel,
    output logic [DATA_WIDTH-1:0]             io_dout,
    input  logic [DATA_WIDTH-1:0]             io_din,
    input  logic                              io_full
);
    localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] is_io, elig;
    logic [IW-1:0]          gnt_id, sel;
    logic                   gnt_any, sel_io, sel_wr;
    logic [DATA_WIDTH-1:0]  sel_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, q_id_q, q_id_d;
    logic                   lock_vld_q, lock_vld_d, q_rvalid_q, q_rvalid_d, q_is_io_q, q_is_io_d;

    always_comb begin
        is_io = '0;
        elig  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            is_io[i] = m_a[i*ADDR_WIDTH+RAM_ADDR_WIDTH-1 +: 2] == 2'b11;
            elig[i]  = m_req[i] & ~(m_wr[i] & is_io[i] & io_full);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (PRIO_EN && elig[PRIO_IDX]) begin
            gnt_any = 1'b1;
            gnt_id  = IW'(PRIO_IDX);
        end else if (lock_vld_q) begin
            gnt_any = elig[lock_id_q];
            gnt_id  = lock_id_q;
        end else begin
            // descending scan: the last hit is the one closest to rr_ptr
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (elig[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
                end
            end
        end
    end

    assign sel    = gnt_any ? gnt_id : '0;
    assign sel_io = is_io[sel];
    assign sel_wr = m_wr[sel];
    assign sel_d  = m_dout[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    assign ram_en   = rst_in & gnt_any & ~sel_io;
    assign io_en    = rst_in & gnt_any & sel_io;
    assign ram_wr   = ram_en & sel_wr;
    assign io_wr    = io_en & sel_wr;
    assign ram_a    = m_a[int'(sel)*ADDR_WIDTH +: RAM_ADDR_WIDTH];
    assign io_sel   = m_a[int'(sel)*ADDR_WIDTH +: 3];
    assign ram_dout = sel_d;
    assign io_dout  = sel_d;
    assign m_din    = q_is_io_q ? io_din : ram_din;

    always_comb begin
        m_gnt             = '0;
        m_rvalid          = '0;
        m_gnt[gnt_id]     = rst_in & gnt_any;
        m_rvalid[q_id_q]  = rst_in & q_rvalid_q;
    end

    always_comb begin
        rr_ptr_d   = gnt_any ? ((gnt_id == IW'(NUM_MASTERS - 1)) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
        lock_vld_d = (gnt_any & m_lock[gnt_id]) | (lock_vld_q & m_req[lock_id_q] & m_lock[lock_id_q]);
        lock_id_d  = (gnt_any & m_lock[gnt_id]) ? gnt_id : lock_id_q;
        q_rvalid_d = gnt_any & ~m_wr[gnt_id];
        q_id_d     = q_rvalid_d ? gnt_id : q_id_q;
        q_is_io_d  = q_rvalid_d ? is_io[gnt_id] : q_is_io_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            q_rvalid_q <= 1'b0;
            q_id_q     <= '0;
            q_is_io_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            q_rvalid_q <= q_rvalid_d;
            q_id_q     <= q_id_d;
            q_is_io_q  <= q_is_io_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a
// behavioural model (N=3, master 0 has absolute priority).
module tb_mem_bus_arbiter;
    localparam int N = 3;

    logic           clk_in = 1'b0, rst_in = 1'b0;
    logic [N-1:0]   m_req = '0, m_wr = '0, m_lock = '0;
    logic [N*32-1:0] m_a = '0;
    logic [N*8-1:0] m_dout = '0;
    logic [N-1:0]   m_gnt, m_rvalid;
    logic [7:0]     m_din, ram_dout, io_dout;
    logic [7:0]     ram_din = 8'h00, io_din = 8'h00;
    logic           ram_en, ram_wr, io_en, io_wr;
    logic           io_full = 1'b0;
    logic [16:0]    ram_a;
    logic [2:0]     io_sel;

    int checks = 0, errors = 0;
    int ptr = 0, owner = -1, pid = 0;
    bit pv = 1'b0, pio = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .DATA_WIDTH(8),
        .PRIO_EN(1'b1), .PRIO_IDX(0)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock),
        .m_a(m_a), .m_dout(m_dout), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_din(m_din),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_dout(io_dout), .io_din(io_din),
        .io_full(io_full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_io(input int i);
        logic [31:0] a;
        a = m_a[i*32 +: 32];
        return a[17:16] == 2'b11;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
        ram_din = 8'($urandom);
        io_din  = 8'($urandom);
    endtask

    task automatic set_m(input int i, input bit rq, input bit w, input bit lk,
                         input logic [31:0] a, input logic [7:0] d);
        m_req[i]        = rq;
        m_wr[i]         = w;
        m_lock[i]       = lk;
        m_a[i*32 +: 32] = a;
        m_dout[i*8 +: 8] = d;
    endtask

    // model: pick the winner from the rules, compare, then advance to the next edge
    always @(negedge clk_in) begin
        int g, s;
        bit io_g, live;
        bit e[N];
        for (int i = 0; i < N; i++) e[i] = m_req[i] && !(m_wr[i] && in_io(i) && io_full);
        g = -1;
        if (e[0]) g = 0;
        else if (owner >= 0) g = e[owner] ? owner : -1;
        else for (int k = 0; k < N; k++) if (g < 0 && e[(ptr + k) % N]) g = (ptr + k) % N;
        s = g < 0 ? 0 : g;
        io_g = in_io(s);
        live = rst_in && g >= 0;
        chk("gnt", m_gnt, live ? (1 << g) : 0);
        chk("rvalid", m_rvalid, (rst_in && pv) ? (1 << pid) : 0);
        if (rst_in && pv) chk("din", m_din, pio ? io_din : ram_din);
        chk("ram_en", ram_en, live && !io_g);
        chk("io_en", io_en, live && io_g);
        chk("ram_wr", ram_wr, live && !io_g && m_wr[s]);
        chk("io_wr", io_wr, live && io_g && m_wr[s]);
        chk("ram_a", ram_a, m_a[s*32 +: 17]);
        chk("io_sel", io_sel, m_a[s*32 +: 3]);
        chk("ram_dout", ram_dout, m_dout[s*8 +: 8]);
        chk("io_dout", io_dout, m_dout[s*8 +: 8]);
        if (!rst_in) begin
            ptr = 0; owner = -1; pv = 1'b0;
        end else begin
            pv = (g >= 0) ? !m_wr[g] : 1'b0;
            if (pv) begin pid = g; pio = io_g; end
            if (g >= 0) ptr = (g + 1) % N;
            if (g >= 0 && m_lock[g]) owner = g;
            else if (owner >= 0 && !(m_req[owner] && m_lock[owner])) owner = -1;
        end
    end

    initial begin
        logic [N-1:0] seen;
        logic [31:0]  a;
        m_req = '1;
        repeat (2) begin
            @(negedge clk_in);
            chk("rst_gnt", m_gnt, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_io_en", io_en, 0);
            chk("rst_rvalid", m_rvalid, 0);
            tick();
        end
        rst_in = 1'b1;
        @(negedge clk_in); chk("first_gnt", m_gnt, 3'b001); tick();
        m_req[0] = 1'b0; set_m(1, 1, 0, 0, 32'h10, 8'h00);
        @(negedge clk_in); chk("rr_a", m_gnt, 3'b010); chk("rr_rv0", m_rvalid, 3'b001);
        chk("rr_ram_a", ram_a, 17'h10); tick();
        @(negedge clk_in); chk("rr_b", m_gnt, 3'b100); chk("rd_rv1", m_rvalid, 3'b010);
        chk("rd_din", m_din, ram_din); tick();
        @(negedge clk_in); chk("rr_c", m_gnt, 3'b010); tick();
        m_req = '0; tick();

        set_m(1, 1, 0, 1, 32'h20, 8'h00);
        @(negedge clk_in); chk("lock_take", m_gnt, 3'b010); tick();
        m_req[2] = 1'b1;
        @(negedge clk_in); chk("lock_hold", m_gnt, 3'b010); tick();
        m_req[0] = 1'b1;
        @(negedge clk_in); chk("prio_preempt", m_gnt, 3'b001); tick();
        m_req[0] = 1'b0; m_lock[1] = 1'b0;
        @(negedge clk_in); chk("lock_resume", m_gnt, 3'b010); tick();
        @(negedge clk_in); chk("lock_release", m_gnt, 3'b100); tick();
        m_req = '0; tick();

        set_m(0, 1, 1, 0, 32'h30000, 8'h41); set_m(1, 1, 0, 0, 32'h4, 8'h00); io_full = 1'b1;
        repeat (3) begin
            @(negedge clk_in); chk("bp_gnt", m_gnt, 3'b010); chk("bp_io_en", io_en, 0);
            chk("bp_ram_en", ram_en, 1); tick();
        end
        io_full = 1'b0;
        @(negedge clk_in); chk("iow_gnt", m_gnt, 3'b001); chk("iow_en", io_en, 1);
        chk("iow_wr", io_wr, 1); chk("iow_sel", io_sel, 0); chk("iow_dout", io_dout, 8'h41);
        chk("iow_ram_en", ram_en, 0); tick();
        m_req = '0; m_wr = '0; tick();

        set_m(2, 1, 0, 0, 32'h30004, 8'h00);
        @(negedge clk_in); chk("ior_gnt", m_gnt, 3'b100); chk("ior_sel", io_sel, 3'd4); tick();
        m_req = '0; set_m(1, 1, 0, 0, 32'h4, 8'h00);
        @(negedge clk_in); chk("ior_rv", m_rvalid, 3'b100); chk("ior_din", m_din, io_din);
        chk("ramr_gnt", m_gnt, 3'b010); tick();
        m_req = '0;
        @(negedge clk_in); chk("ramr_rv", m_rvalid, 3'b010); chk("ramr_din", m_din, ram_din); tick();

        set_m(2, 1, 0, 1, 32'h8, 8'h00);
        @(negedge clk_in); chk("mid_gnt", m_gnt, 3'b100); tick();
        rst_in = 1'b0;
        @(negedge clk_in); chk("mid_rv", m_rvalid, 0); chk("mid_gnt0", m_gnt, 0); tick();
        rst_in = 1'b1; set_m(1, 1, 0, 0, 32'hc, 8'h00);
        @(negedge clk_in); chk("post_rst_gnt", m_gnt, 3'b010); chk("post_rst_rv", m_rvalid, 0); tick();
        m_req = '0; m_lock = '0; tick();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_in);
            seen = m_gnt;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] || seen[i]) begin
                    a = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h0003_0000) : ($urandom & 32'hfffe_ffff);
                    set_m(i, $urandom_range(0, 99) < 60, 1'($urandom), $urandom_range(0, 9) == 0,
                          a, 8'($urandom));
                end
            end
            io_full = $urandom_range(0, 3) == 0;
            rst_in  = $urandom_range(0, 199) != 0;
        end
        @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master memory-bus arbiter and address decoder; generalises the fixed CPU/HCI two-way mux at top level.
- Grants one master per cycle to a shared byte bus. Decodes each access to RAM or the IO window.
- Returns read data one cycle later to the issuing master, selecting RAM or IO data from a registered region tag.
- Supports round-robin arbitration, an optional absolute-priority (debug) master, bus locking, and IO-write backpressure.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..8)
ADDR_WIDTH, 32, master address width
RAM_ADDR_WIDTH, 17, RAM address width; IO window = a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
DATA_WIDTH, 8, data width
PRIO_EN, 1, 1 = master PRIO_IDX has absolute priority
PRIO_IDX, 0, index of priority master

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-low reset
m_req  input  NUM_MASTERS  access request per master
m_wr  input  NUM_MASTERS  1 = write, 0 = read
m_lock  input  NUM_MASTERS  hold bus after grant
m_a  input  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dout  input  NUM_MASTERS*DATA_WIDTH  packed write data
m_gnt  output  NUM_MASTERS  one-hot; access accepted this cycle
m_rvalid  output  NUM_MASTERS  one-hot; read data valid for master i
m_din  output  DATA_WIDTH  shared read-return data
ram_en  output  1  RAM enable
ram_wr  output  1  RAM write
ram_a  output  RAM_ADDR_WIDTH  RAM address
ram_dout  output  DATA_WIDTH  RAM write data
ram_din  input  DATA_WIDTH  RAM read data (synchronous, 1-cycle)
io_en  output  1  IO access strobe
io_wr  output  1  IO write
io_sel  output  3  IO register select = a[2:0]
io_dout  output  DATA_WIDTH  IO write data
io_din  input  DATA_WIDTH  IO read data (1-cycle)
io_full  input  1  IO write buffer full

Behaviour:
- Reset is sampled at the clk_in edge while rst_in=0. Effect: rr_ptr=0, lock_owner invalid, q_rvalid=0, q_is_io=0, q_id=0.
- While rst_in=0, these outputs are forced to 0: m_gnt, m_rvalid, ram_en, io_en, ram_wr, io_wr.
- Eligibility (combinational): master i is eligible when m_req[i]=1, unless it is an IO write (m_wr[i]=1 and IO window) while io_full=1.
- Grant (combinational, same cycle), first rule that applies wins:
  - PRIO_EN and PRIO_IDX eligible -> grant PRIO_IDX. This preempts any lock held by another master.
  - Lock owner valid -> grant the owner if eligible, else nobody.
  - Otherwise round-robin: first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - No eligible master -> m_gnt=0, ram_en=0, io_en=0.
- Datapath from granted master g:
  - IO window: io_en=1, ram_en=0, io_wr=m_wr[g], io_sel=a[2:0], io_dout=m_dout[g].
  - Otherwise: ram_en=1, io_en=0, ram_wr=m_wr[g], ram_a=a[RAM_ADDR_WIDTH-1:0], ram_dout=m_dout[g].
  - Idle: ram_a, io_sel and data outputs hold the master-0 value; enables are 0.
- Sequential updates on each edge with a grant to g:
  - rr_ptr <= (g+1) mod NUM_MASTERS. Priority grants also update rr_ptr.
  - m_lock[g]=1 -> lock_owner <= g.
  - Owner granted or requesting with m_lock=0 -> owner cleared. An owner dropping m_req also clears it.
- Read return:
  - A granted read sets q_rvalid=1, q_id=g, q_is_io=IO-window flag.
  - The next cycle: m_rvalid[q_id]=1 and m_din = q_is_io ? io_din : ram_din.
  - Writes never produce rvalid.
  - Back-to-back reads are pipelined, one per cycle, in grant order.
- m_din is don't-care-but-stable when no rvalid: holds the last mux value.
- A master must hold req/wr/a/dout stable until it sees m_gnt.
- Reset mid-read: the pending rvalid is dropped; no return after reset.
- io_full rises while an IO write is pending: that master waits. Others proceed; an IO read is not blocked.
- Outputs use single-level mux logic; no combinational path from ram_din/io_din to m_gnt.

Test Plan:
- Reset: rst_in=0 for 2 cycles with all m_req=1 -> m_gnt=0, ram_en=io_en=0, m_rvalid=0. First cycle after release grants PRIO_IDX=0.
- Round-robin: PRIO_EN=0, N=3, all req held 6 cycles -> grants 0,1,2,0,1,2. Master-1 read of 0x00010 returns ram_din with m_rvalid=3'b010 one cycle after its grant.
- Priority preemption: master 1 holds lock with reads; master 0 asserts req at cycle 5 -> cycle 5 m_gnt=2'b01. Cycle 6 returns to master 1 if master 0 drops req.
- IO decode/backpressure: master 0 writes 0x30000 data 0x41 with io_full=1 for 3 cycles -> no gnt, io_en=0. On io_full=0: io_en=1, io_sel=0, io_dout=0x41, ram_en=0. Meanwhile master 1 RAM reads are granted.
- IO read return select: read 0x30004 then RAM 0x00004 back-to-back -> m_din=io_din in cycle+1, then ram_din in cycle+2, with correct per-master m_rvalid.
- Reset mid-operation: grant read, assert rst_in=0 next cycle -> no m_rvalid; lock_owner cleared; rr_ptr=0.
